data_mem_stage: RTL and testbench

- MEM-stage data memory controller, directly downstream of the EX/MEM pipeline register.
- Consumes the registered MemRead/MemWrite controls, the ALU result (used as the address) and ReadData2 (used as store data).
- Performs word, halfword and byte loads and stores against an internal word-organised RAM with a configurable wait-state latency.
- Asserts a stall to freeze the upstream pipeline while an access is in flight; the result feeds the MEM/WB register.

---
 rtl/data_mem_stage.sv | 199 +++++++++++++++++++
 tb/tb_data_mem_stage.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_stage.sv
// data_mem_stage: MEM-stage data memory controller fed by the EX/MEM register.
// Performs byte/halfword/word loads and stores against an internal
// word-organised RAM with LATENCY wait states. The upstream pipeline is
// frozen via Stall_out while an access is in flight.
//
// Optional feature: define DMEM_MISALIGN_COUNT_EN to add a saturating
// 16-bit counter of misaligned requests (MisalignCount_out).
//
// Ports:
//   Clk, Rst            clock, synchronous active-high reset
//   MemRead_in          load request
//   MemWrite_in         store request (wins when both are high)
//   MemSize_in          00 byte, 01 halfword, 10/11 word
//   MemSigned_in        loads: 1 sign-extend, 0 zero-extend
//   Address_in          byte address (ALU result)
//   WriteData_in        store data (low lanes used for sub-word stores)
//   ReadData_out        registered, extended load result
//   Stall_out           combinational; high while the stage is occupied
//   Misalign_out        one-cycle pulse for a rejected misaligned request
//   MisalignCount_out   (optional) saturating misalign pulse count
module data_mem_stage #(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 2
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic [1:0]  MemSize_in,
   input  logic        MemSigned_in,
   input  logic [31:0] Address_in,
   input  logic [31:0] WriteData_in,
   output logic [31:0] ReadData_out,
   output logic        Stall_out,
   output logic        Misalign_out
`ifdef DMEM_MISALIGN_COUNT_EN
   ,
   output logic [15:0] MisalignCount_out
`endif
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned AW    = IDX_W + 2;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   // Request captured when an access is accepted
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [1:0]    size;
      logic          sgn;
      logic          wr;
      logic [31:0]   wdata;
   } req_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   req_t             req_q;
   logic [31:0]      mem [DEPTH];

   logic             req;
   logic             aligned;
   logic             commit;
   logic [31:0]      rd_word;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [31:0]      ld_ext;
   logic [3:0]       st_be;
   logic [31:0]      st_data;

   // Address bits above the RAM index are ignored, so addresses wrap
   logic [31-AW:0]   unused_addr_hi;
   assign unused_addr_hi = Address_in[31:AW];

   assign req = MemRead_in | MemWrite_in;

   // Alignment check on the incoming request
   always_comb begin
      aligned = 1'b1;
      case (MemSize_in)
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~Address_in[0];
         default: aligned = (Address_in[1:0] == 2'b00);
      endcase
   end

   // Stall is combinational so the request cycle itself is frozen
   assign Stall_out = ~Rst & (((state == IDLE) & req & aligned) | (state == WAIT));

   // Last wait-state cycle: the store commits / load result registers
   assign commit = (state == WAIT) && (cnt == CNT_W'(1));

   assign rd_word = mem[req_q.addr[AW-1:2]];

   // Load lane select and extension
   always_comb begin
      ld_byte = rd_word[7:0];
      case (req_q.addr[1:0])
         2'd0: ld_byte = rd_word[7:0];
         2'd1: ld_byte = rd_word[15:8];
         2'd2: ld_byte = rd_word[23:16];
         2'd3: ld_byte = rd_word[31:24];
         default: ld_byte = rd_word[7:0];
      endcase
      ld_half = req_q.addr[1] ? rd_word[31:16] : rd_word[15:0];
      ld_ext  = rd_word;
      case (req_q.size)
         2'b00:   ld_ext = req_q.sgn ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
         2'b01:   ld_ext = req_q.sgn ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
         default: ld_ext = rd_word;
      endcase
   end

   // Store byte enables with data replicated across the lanes
   always_comb begin
      st_be   = 4'b1111;
      st_data = req_q.wdata;
      case (req_q.size)
         2'b00: begin
            st_be   = 4'b0001 << req_q.addr[1:0];
            st_data = {4{req_q.wdata[7:0]}};
         end
         2'b01: begin
            st_be   = req_q.addr[1] ? 4'b1100 : 4'b0011;
            st_data = {2{req_q.wdata[15:0]}};
         end
         default: begin
            st_be   = 4'b1111;
            st_data = req_q.wdata;
         end
      endcase
   end

   // RAM write port; contents are not touched by reset
   always_ff @(posedge Clk) begin
      if (!Rst && commit && req_q.wr) begin
         for (int i = 0; i < 4; i++) begin
            if (st_be[i]) begin
               mem[req_q.addr[AW-1:2]][8*i +: 8] <= st_data[8*i +: 8];
            end
         end
      end
   end

   // Access sequencer: IDLE -> WAIT -> DONE -> IDLE
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state        <= IDLE;
         cnt          <= '0;
         req_q        <= '0;
         ReadData_out <= '0;
         Misalign_out <= 1'b0;
`ifdef DMEM_MISALIGN_COUNT_EN
         MisalignCount_out <= '0;
`endif
      end else begin
         Misalign_out <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  if (aligned) begin
                     req_q.addr  <= Address_in[AW-1:0];
                     req_q.size  <= MemSize_in;
                     req_q.sgn   <= MemSigned_in;
                     req_q.wr    <= MemWrite_in;
                     req_q.wdata <= WriteData_in;
                     cnt         <= CNT_W'(LATENCY);
                     state       <= WAIT;
                  end else begin
                     Misalign_out <= 1'b1;
                     ReadData_out <= '0;
`ifdef DMEM_MISALIGN_COUNT_EN
                     if (MisalignCount_out != 16'hFFFF) begin
                        MisalignCount_out <= MisalignCount_out + 16'd1;
                     end
`endif
                  end
               end
            end
            WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (commit) begin
                  state        <= DONE;
                  ReadData_out <= req_q.wr ? 32'd0 : ld_ext;
               end
            end
            // EX/MEM still presents the finished request here; ignore it
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_stage.sv
module tb_data_mem_stage;

   logic        Clk;
   logic        Rst;
   logic        MemRead_in;
   logic        MemWrite_in;
   logic [1:0]  MemSize_in;
   logic        MemSigned_in;
   logic [31:0] Address_in;
   logic [31:0] WriteData_in;
   logic [31:0] ReadData_out;
   logic        Stall_out;
   logic        Misalign_out;
`ifdef DMEM_MISALIGN_COUNT_EN
   logic [15:0] MisalignCount_out;
`endif

   int tests_run;
   int tests_failed;

   data_mem_stage #(.DEPTH(1024), .LATENCY(2)) dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .MemRead_in   (MemRead_in),
      .MemWrite_in  (MemWrite_in),
      .MemSize_in   (MemSize_in),
      .MemSigned_in (MemSigned_in),
      .Address_in   (Address_in),
      .WriteData_in (WriteData_in),
      .ReadData_out (ReadData_out),
      .Stall_out    (Stall_out),
      .Misalign_out (Misalign_out)
`ifdef DMEM_MISALIGN_COUNT_EN
      ,
      .MisalignCount_out (MisalignCount_out)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic set_idle();
      MemRead_in   = 1'b0;
      MemWrite_in  = 1'b0;
      MemSize_in   = 2'b10;
      MemSigned_in = 1'b0;
      Address_in   = 32'd0;
      WriteData_in = 32'd0;
   endtask

   // Drives one request from an IDLE cycle; returns the number of stall
   // cycles seen and ReadData_out in the DONE cycle. Ends 1ns into the
   // following IDLE cycle with inputs idle.
   task automatic mem_access(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] rdata, output int n);
      MemRead_in   = rd;
      MemWrite_in  = wr;
      MemSize_in   = sz;
      MemSigned_in = sg;
      Address_in   = addr;
      WriteData_in = wd;
      n = 0;
      #1;
      while (Stall_out === 1'b1 && n < 40) begin
         n++;
         @(posedge Clk); #1;
      end
      rdata = ReadData_out;
      @(posedge Clk); #1;
      set_idle();
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      set_idle();
      repeat (3) @(posedge Clk);
      #1;
      tests_run++;
      if (ReadData_out !== 32'd0) begin
         tests_failed++;
         $display("FAIL reset_rdata: got %h expected %h", ReadData_out, 32'd0);
      end
      tests_run++;
      if (Stall_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_stall: got %b expected 0", Stall_out);
      end
      tests_run++;
      if (Misalign_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_misalign: got %b expected 0", Misalign_out);
      end
      Rst = 1'b0;
   endtask

   task automatic test_store_word();
      logic [31:0] rd;
      int n;
      mem_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, n);
      tests_run++;
      if (n !== 3) begin
         tests_failed++;
         $display("FAIL sw_stall_cycles: got %0d expected 3", n);
      end
      tests_run++;
      if (rd !== 32'd0) begin
         tests_failed++;
         $display("FAIL sw_rdata: got %h expected %h", rd, 32'd0);
      end
      mem_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, n);
      tests_run++;
      if (n !== 3) begin
         tests_failed++;
         $display("FAIL lw_stall_cycles: got %0d expected 3", n);
      end
      tests_run++;
      if (rd !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL lw_deadbeef: got %h expected %h", rd, 32'hDEADBEEF);
      end
   endtask

   task automatic test_byte_loads();
      logic [31:0] rd;
      int n;
      mem_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'd0, rd, n);
      tests_run++;
      if (rd !== 32'hFFFFFFDE) begin
         tests_failed++;
         $display("FAIL lb_0x13: got %h expected %h", rd, 32'hFFFFFFDE);
      end
      mem_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'd0, rd, n);
      tests_run++;
      if (rd !== 32'h000000EF) begin
         tests_failed++;
         $display("FAIL lbu_0x10: got %h expected %h", rd, 32'h000000EF);
      end
      mem_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, rd, n);
      tests_run++;
      if (rd !== 32'h0000DEAD) begin
         tests_failed++;
         $display("FAIL lhu_0x12: got %h expected %h", rd, 32'h0000DEAD);
      end
      mem_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'd0, rd, n);
      tests_run++;
      if (rd !== 32'hFFFFDEAD) begin
         tests_failed++;
         $display("FAIL lh_0x12: got %h expected %h", rd, 32'hFFFFDEAD);
      end
      mem_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'd0, rd, n);
      tests_run++;
      if (rd !== 32'h000000BE) begin
         tests_failed++;
         $display("FAIL lbu_0x11: got %h expected %h", rd, 32'h000000BE);
      end
      mem_access(1'b1, 1'b0, 2'b10, 1'b1, 32'h10, 32'd0, rd, n);
      tests_run++;
      if (rd !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL lw_signed_ignored: got %h expected %h", rd, 32'hDEADBEEF);
      end
   endtask

   task automatic test_subword_stores();
      logic [31:0] rd;
      int n;
      mem_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, rd, n);
      mem_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'hAAAAAA77, rd, n);
      mem_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, n);
      tests_run++;
      if (rd !== 32'h1234BE77) begin
         tests_failed++;
         $display("FAIL subword_merge: got %h expected %h", rd, 32'h1234BE77);
      end
   endtask

   // One misaligned request held for a single cycle
   task automatic misalign_req(input logic rd, input logic wr, input logic [1:0] sz,
                               input logic [31:0] addr, input string tag);
      MemRead_in   = rd;
      MemWrite_in  = wr;
      MemSize_in   = sz;
      Address_in   = addr;
      WriteData_in = 32'h0;
      #1;
      tests_run++;
      if (Stall_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s_stall: got %b expected 0", tag, Stall_out);
      end
      @(posedge Clk); #1;
      set_idle();
      tests_run++;
      if (Misalign_out !== 1'b1 || ReadData_out !== 32'd0) begin
         tests_failed++;
         $display("FAIL %s_pulse: got misalign=%b rdata=%h expected misalign=1 rdata=0",
                  tag, Misalign_out, ReadData_out);
      end
      @(posedge Clk); #1;
      tests_run++;
      if (Misalign_out !== 1'b0 || Stall_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s_pulse_end: got misalign=%b stall=%b expected 0 0",
                  tag, Misalign_out, Stall_out);
      end
   endtask

   task automatic test_misalign();
      logic [31:0] rd;
      int n;
      misalign_req(1'b1, 1'b0, 2'b01, 32'h11, "lh_0x11");
      misalign_req(1'b1, 1'b0, 2'b10, 32'h12, "lw_0x12");
      misalign_req(1'b0, 1'b1, 2'b10, 32'h11, "sw_0x11");
`ifdef DMEM_MISALIGN_COUNT_EN
      tests_run++;
      if (MisalignCount_out !== 16'd3) begin
         tests_failed++;
         $display("FAIL misalign_count: got %0d expected 3", MisalignCount_out);
      end
`endif
      mem_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, n);
      tests_run++;
      if (rd !== 32'h1234BE77) begin
         tests_failed++;
         $display("FAIL misalign_mem_unchanged: got %h expected %h", rd, 32'h1234BE77);
      end
   endtask

   task automatic test_reset_mid_access();
      logic [31:0] rd;
      int n;
      mem_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5A5A5, rd, n);
      mem_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, rd, n);
      tests_run++;
      if (rd !== 32'hA5A5A5A5) begin
         tests_failed++;
         $display("FAIL pre_reset_lw: got %h expected %h", rd, 32'hA5A5A5A5);
      end
      MemWrite_in  = 1'b1;
      MemSize_in   = 2'b10;
      Address_in   = 32'h20;
      WriteData_in = 32'h00000055;
      @(posedge Clk); #1;
      tests_run++;
      if (Stall_out !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_wait_stall: got %b expected 1", Stall_out);
      end
      Rst = 1'b1;
      set_idle();
      @(posedge Clk); #1;
      tests_run++;
      if (ReadData_out !== 32'd0 || Stall_out !== 1'b0 || Misalign_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_outputs: got rdata=%h stall=%b misalign=%b expected 0 0 0",
                  ReadData_out, Stall_out, Misalign_out);
      end
`ifdef DMEM_MISALIGN_COUNT_EN
      tests_run++;
      if (MisalignCount_out !== 16'd0) begin
         tests_failed++;
         $display("FAIL abort_count_clear: got %0d expected 0", MisalignCount_out);
      end
`endif
      Rst = 1'b0;
      mem_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, rd, n);
      tests_run++;
      if (rd !== 32'hA5A5A5A5 || n !== 3) begin
         tests_failed++;
         $display("FAIL abort_store_dropped: got %h/%0d expected %h/3", rd, n, 32'hA5A5A5A5);
      end
      mem_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, n);
      tests_run++;
      if (rd !== 32'h1234BE77) begin
         tests_failed++;
         $display("FAIL ram_survives_reset: got %h expected %h", rd, 32'h1234BE77);
      end
   endtask

   task automatic test_wrap_priority();
      logic [31:0] rd;
      int n;
      mem_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h00000011, rd, n);
      mem_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h1010, 32'd0, rd, n);
      tests_run++;
      if (rd !== 32'h1234BE11) begin
         tests_failed++;
         $display("FAIL wrap_lw_0x1010: got %h expected %h", rd, 32'h1234BE11);
      end
      mem_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, rd, n);
      tests_run++;
      if (rd !== 32'd0 || n !== 3) begin
         tests_failed++;
         $display("FAIL both_high_store: got %h/%0d expected 0/3", rd, n);
      end
      mem_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, n);
      tests_run++;
      if (rd !== 32'd0) begin
         tests_failed++;
         $display("FAIL both_high_mem: got %h expected %h", rd, 32'd0);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      int n;
      mem_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, rd, n);
      tests_run++;
      if (n !== 3) begin
         tests_failed++;
         $display("FAIL b2b_sh_stall: got %0d expected 3", n);
      end
      mem_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, rd, n);
      tests_run++;
      if (rd !== 32'hBEEFA5A5 || n !== 3) begin
         tests_failed++;
         $display("FAIL b2b_lw: got %h/%0d expected %h/3", rd, n, 32'hBEEFA5A5);
      end
      mem_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h23, 32'd0, rd, n);
      tests_run++;
      if (rd !== 32'hFFFFFFBE || n !== 3) begin
         tests_failed++;
         $display("FAIL b2b_lb: got %h/%0d expected %h/3", rd, n, 32'hFFFFFFBE);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      Rst          = 1'b1;
      set_idle();
      test_reset();
      test_store_word();
      test_byte_loads();
      test_subword_stores();
      test_misalign();
      test_reset_mid_access();
      test_wrap_priority();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
